flow_ctrl_unit: RTL

- Control-flow sequencer that sits upstream of the program counter and drives its pc_enable, pc_sel and target address inputs.
- Accepts decoded control-flow ops (NOP, JMP, BEQ, BNE, CALL, RET) with the current pc and zero flag, and resolves branch conditions.
- Maintains a hardware return-address stack for CALL/RET.
- Inserts a one-cycle flush bubble after every redirect.

---
 rtl/flow_ctrl_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/flow_ctrl_unit.sv
// flow_ctrl_unit: resolves control-flow ops for the pc, keeps a return-address stack, and flushes after each redirect.
// Optional feature: define REDIRECT_CNT_EN to build the saturating taken-redirect counter.
module flow_ctrl_unit #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op,
  input  logic          zero_flag,
  input  logic [AW-1:0] imm_addr,
  input  logic [AW-1:0] pc,
  output logic          pc_enable,
  output logic [1:0]    pc_sel,
  output logic [AW-1:0] target_addr,
  output logic          flush,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          stack_err,
  output logic [15:0]   redirect_cnt
);
  localparam int SPW = $clog2(DEPTH) + 1;
  localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_EMPTY = {SPW{1'b0}};

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_BNE  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  localparam logic [1:0] SEL_INC  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JUMP = 2'b10;
  localparam logic [1:0] SEL_RET  = 2'b11;

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t          r_state;
  logic            r_op_ready;
  logic            r_pc_enable;
  logic [1:0]      r_pc_sel;
  logic [AW-1:0]   r_target;
  logic            r_flush;
  logic [SPW-1:0]  r_sp;
  logic            r_stack_full;
  logic            r_stack_empty;
  logic            r_stack_err;
  logic [AW-1:0]   r_stack [DEPTH];

  logic            w_accept;
  logic [1:0]      w_sel;
  logic [AW-1:0]   w_target;
  logic            w_push;
  logic            w_pop;
  logic            w_err;
  logic [SPW-1:0]  w_sp_m1;
  logic [SPW-1:0]  w_sp_nxt;

  function automatic logic branch_taken(input logic [2:0] f_op, input logic f_zero);
    return ((f_op == OP_BEQ) && f_zero) || ((f_op == OP_BNE) && !f_zero);
  endfunction

  assign w_accept = op_valid && r_op_ready && (r_state == S_IDLE) && !rst;
  assign w_sp_m1  = r_sp - SPW'(1);

  // Decode the accepted op into a pc selection and any stack push/pop.
  always_comb begin
    w_sel    = SEL_INC;
    w_target = {AW{1'b0}};
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_err    = 1'b0;
    if (w_accept) begin
      case (op)
        OP_JMP: begin
          w_sel    = SEL_JUMP;
          w_target = imm_addr;
        end
        OP_BEQ, OP_BNE: begin
          if (branch_taken(op, zero_flag)) begin
            w_sel    = SEL_BR;
            w_target = imm_addr;
          end else begin
            w_sel    = SEL_INC;
          end
        end
        OP_CALL: begin
          w_sel    = SEL_JUMP;
          w_target = imm_addr;
          if (r_sp == SP_FULL) begin
            w_err  = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        OP_RET: begin
          // A RET on an empty stack degrades to a plain increment.
          if (r_sp == SP_EMPTY) begin
            w_err    = 1'b1;
          end else begin
            w_sel    = SEL_RET;
            w_target = r_stack[w_sp_m1[SPW-2:0]];
            w_pop    = 1'b1;
          end
        end
        default: w_sel = SEL_INC;
      endcase
    end else begin
      w_sel = SEL_INC;
    end
  end

  assign w_sp_nxt = w_push ? (r_sp + SPW'(1)) : (w_pop ? w_sp_m1 : r_sp);

  // Sequencer state, registered pc strobe and stack pointer/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op_ready    <= 1'b1;
      r_pc_enable   <= 1'b0;
      r_pc_sel      <= SEL_INC;
      r_target      <= {AW{1'b0}};
      r_flush       <= 1'b0;
      r_sp          <= SP_EMPTY;
      r_stack_full  <= 1'b0;
      r_stack_empty <= 1'b1;
      r_stack_err   <= 1'b0;
    end else begin
      r_sp          <= w_sp_nxt;
      r_stack_full  <= (w_sp_nxt == SP_FULL);
      r_stack_empty <= (w_sp_nxt == SP_EMPTY);
      r_stack_err   <= r_stack_err | w_err;
      r_pc_enable   <= w_accept;
      if (w_accept) begin
        r_pc_sel <= w_sel;
        r_target <= w_target;
      end
      case (r_state)
        S_IDLE: begin
          r_flush <= 1'b0;
          // Readiness drops with the redirect strobe so no wrong-path op slips in.
          if (w_accept && (w_sel != SEL_INC)) begin
            r_state    <= S_FLUSH;
            r_op_ready <= 1'b0;
          end else begin
            r_op_ready <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_flush    <= 1'b1;
          r_op_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_flush    <= 1'b0;
          r_op_ready <= 1'b1;
        end
      endcase
    end
  end

  // Return-address storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_sp[SPW-2:0]] <= pc + AW'(1);
    end
  end

`ifdef REDIRECT_CNT_EN
  logic [15:0] r_redirect_cnt;

  // Saturating count of taken redirects seen on the pc strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_cnt <= 16'h0000;
    end else if (r_pc_enable && (r_pc_sel != SEL_INC) && (r_redirect_cnt != 16'hFFFF)) begin
      r_redirect_cnt <= r_redirect_cnt + 16'h0001;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
`else
  assign redirect_cnt = 16'h0000;
`endif

  assign op_ready    = r_op_ready;
  assign pc_enable   = r_pc_enable;
  assign pc_sel      = r_pc_sel;
  assign target_addr = r_target;
  assign flush       = r_flush;
  assign stack_full  = r_stack_full;
  assign stack_empty = r_stack_empty;
  assign stack_err   = r_stack_err;

endmodule
